// File: rtl/prog_feeder_pkg.sv
// Shared constants for the program feeder and the processor it drives.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package prog_feeder_pkg;

    localparam int CMD_LENGTH = 6;
    localparam int FEED_ADDR_W = 4;
    localparam int FEED_DEPTH = 16;

    localparam logic [1:0] CMD_MV  = 2'b00;
    localparam logic [1:0] CMD_MVI = 2'b01;
    localparam logic [1:0] CMD_ADD = 2'b10;
    localparam logic [1:0] CMD_SUB = 2'b11;

    typedef enum logic [1:0] {
        FEED_IDLE  = 2'd0,
        FEED_FETCH = 2'd1,
        FEED_IMM   = 2'd2,
        FEED_EXEC  = 2'd3
    } feed_state_t;

    // Opcode field of an instruction word.
    function automatic logic [1:0] cmd_op(input logic [CMD_LENGTH-1:0] word);
        return word[5:4];
    endfunction

endpackage

// File: rtl/prog_ram.sv
// Program memory: DEPTH x W register array, synchronous write, combinational read.
// Latency: write visible the cycle after the write edge; read is zero-cycle.
// Backpressure: none; the write strobe is gated by the caller.
module prog_ram #(
    parameter int W     = 6,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; the program survives a reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_feeder.sv
// Feeds a stored program to the processor over DIN, driving run and using done as handshake.
// Latency: MV/MVI 2 cycles, ADD/SUB 4 cycles from one FETCH to the next.
// Backpressure: FETCH holds until Tstep==0; IMM/EXEC hold until done.
module prog_feeder
    import prog_feeder_pkg::*;
#(
    parameter int CMD_W  = CMD_LENGTH,
    parameter int ADDR_W = FEED_ADDR_W,
    parameter int DEPTH  = FEED_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [CMD_W-1:0]  prog_wdata,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic [1:0]        Tstep,
    input  logic              done,
    output logic [CMD_W-1:0]  DIN,
    output logic              run,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              err
);

    feed_state_t       state;
    // One bit wider than pc so that len==DEPTH is distinguishable from 0.
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_inc;
    logic [ADDR_W:0]   len_q;
    logic [CMD_W-1:0]  rd_word;
    logic              idle;

    assign idle    = (state == FEED_IDLE);
    assign cnt_inc = cnt + 1'b1;
    assign pc      = cnt[ADDR_W-1:0];

    prog_ram #(
        .W     (CMD_W),
        .AW    (ADDR_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (prog_we && idle),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (pc),
        .rdata (rd_word)
    );

    // Sequencer: walks the program, one word per commit, ending on the length count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FEED_IDLE;
            cnt   <= '0;
            len_q <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                FEED_IDLE: begin
                    if (start) begin
                        len_q <= prog_len;
                        cnt   <= '0;
                        err   <= 1'b0;
                        state <= (prog_len == '0) ? FEED_IDLE : FEED_FETCH;
                    end
                end
                FEED_FETCH: begin
                    // Tstep==0 is the edge on which the processor loads IR.
                    if (Tstep == 2'd0) begin
                        cnt <= cnt_inc;
                        if (cmd_op(rd_word) == CMD_MVI) begin
                            if (cnt_inc == len_q) begin
                                err   <= 1'b1;
                                state <= FEED_IDLE;
                            end else begin
                                state <= FEED_IMM;
                            end
                        end else begin
                            state <= FEED_EXEC;
                        end
                    end
                end
                FEED_IMM: begin
                    if (done) begin
                        cnt   <= cnt_inc;
                        state <= (cnt_inc == len_q) ? FEED_IDLE : FEED_FETCH;
                    end
                end
                FEED_EXEC: begin
                    if (done) begin
                        state <= (cnt == len_q) ? FEED_IDLE : FEED_FETCH;
                    end
                end
                default: state <= FEED_IDLE;
            endcase
        end
    end

    // Outputs decode straight from the state register so run drops right after the last done.
    assign run  = !idle;
    assign busy = !idle;
    assign DIN  = (state == FEED_FETCH || state == FEED_IMM) ? rd_word : '0;

endmodule

// File: doc/prog_feeder.md
Name: prog_feeder

Overview:
- Instruction/operand source directly upstream of the processor control unit.
- Holds a small writable program memory and drives the processor's DIN bus and run line.
- Steps through the program one instruction at a time, supplying the immediate word for MVI, and uses the processor's done pulse as the completion handshake.
- Replaces the manual DIN switches and run switch so that multi-instruction programs run unattended.

Parameters:
- CMD_W, `CMD_LENGTH (from config.vh): instruction/data word width; bits [5:4] = opcode, [3:2] = X, [1:0] = Y.
- ADDR_W, 4: program memory address width.
- DEPTH, 16: program memory words, equal to 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- prog_we  in  1  program write strobe; honoured only in IDLE.
- prog_addr  in  ADDR_W  program write address.
- prog_wdata  in  CMD_W  program write data.
- prog_len  in  ADDR_W+1  number of valid words (0..DEPTH); sampled on start.
- start  in  1  one-cycle pulse; begins execution from address 0.
- Tstep  in  2  processor step counter value.
- done  in  1  processor instruction-complete pulse.
- DIN  out  CMD_W  processor data-in bus.
- run  out  1  processor run enable.
- pc  out  ADDR_W  address of the word currently presented.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky; truncated MVI detected; cleared by start or reset.

Behaviour:
- Reset (asynchronous, reset=1): state IDLE, pc=0, run=0, DIN=0, busy=0, err=0, latched length=0. Memory contents are not reset.
- Memory: DEPTH x CMD_W register array, synchronous write, combinational read. prog_we outside IDLE is ignored.
- Opcode encodings come from config.vh: MV=2'b00, MVI=2'b01, ADD=2'b10, SUB=2'b11.
- FSM states: IDLE, FETCH, IMM, EXEC.
- IDLE:
  - run=0, DIN=0.
  - On start: latch prog_len, pc<=0, err<=0.
  - If prog_len==0, stay in IDLE; otherwise go to FETCH.
  - start outside IDLE is ignored.
- FETCH:
  - run=1, DIN=mem[pc].
  - Commits only when Tstep==0; this is the processor's IR load edge. If Tstep!=0, hold.
  - On commit, pc<=pc+1.
  - If DIN[5:4]==MVI and pc+1==len: set err, go to IDLE (run drops next cycle).
  - Else if DIN[5:4]==MVI: go to IMM.
  - Else: go to EXEC.
- IMM:
  - run=1, DIN=mem[pc] (the immediate word).
  - The processor asserts done in this cycle (T1).
  - On done: pc<=pc+1; go to IDLE if pc+1==len, else FETCH.
  - Without done: hold.
- EXEC:
  - run=1, DIN=0.
  - Wait for done: MV completes at T1, ADD/SUB at T3.
  - On done: go to IDLE if pc==len, else FETCH.
- Latency per instruction, FETCH to next FETCH: MV = 2 cycles, MVI = 2 cycles, ADD/SUB = 4 cycles.
- run is combinational from state, so it is low in the cycle after the final done. The processor's clr (done, or ~run at Tstep 0) therefore holds Tstep at 0.
- pc wraps modulo DEPTH. Because len<=DEPTH, end detection compares an (ADDR_W+1)-bit counter, so len==DEPTH terminates correctly.
- done outside IMM/EXEC is ignored.
- Reset mid-program aborts immediately with the reset values above.

Decomposition:
- config.vh, shared across the processor: CMD_LENGTH, opcode constants CMD_MV/CMD_MVI/CMD_ADD/CMD_SUB, and new FSM state encodings FEED_IDLE/FEED_FETCH/FEED_IMM/FEED_EXEC (2 bits).
- One sub-module, prog_ram: DEPTH x CMD_W array, synchronous write port, asynchronous read port.
- FSM and pc logic stay in prog_feeder.

Test Plan:
- Load {MVI R0 (6'b010000), 6'd5, MV R1,R0 (6'b000100)}, prog_len=3, start:
  - DIN sequence is 010000, 000101, 000100.
  - run high for exactly 4 cycles.
  - busy falls after done in the MV T1 cycle; pc ends at 3.
- Load ADD R0,R1 (6'b100001), prog_len=1:
  - run held through T0..T3.
  - DIN=0 during EXEC.
  - IDLE is entered on the edge after done at Tstep=3.
- Load a single MVI (prog_len=1):
  - err=1, pc=1, run=0 within 2 cycles of start.
  - The next start clears err.
- Issue prog_we while busy=1 with addr 0 and data 6'b111111:
  - After completion, a readback of the word at address 0 is unchanged.
- Assert reset during IMM:
  - run, DIN, pc, busy, err all read 0 in the same cycle.
  - The FSM is in IDLE and re-runs correctly on start.
- prog_len=16 with 16 MV words:
  - pc wraps to 0 after the final commit.
  - The FSM enters IDLE after the 16th done; no 17th fetch occurs.
